dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage (core) and a DMA/debug port.
//  - Core has fixed priority. A starvation counter forces one DMA grant after STARVE_LIMIT

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb_starve_ctr.sv | 31 +++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration state, read owner, and request bundle.
package dmem_arb_pkg;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive denied DMA cycles and flags the cycle whose denial reaches the limit.
module dmem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_req,
    input  logic          dma_gnt,
    output logic [CW-1:0] starve_cnt,
    output logic          force_hit
);

    localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

    logic denied;

    assign denied    = dma_req && !dma_gnt;
    assign force_hit = denied && (starve_cnt == LIMIT_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (denied) begin
            starve_cnt <= starve_cnt + CW'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the single-port dmem with DMA starvation relief and read-return routing.
// Optional ARB_PERF_EN macro builds saturating conflict / forced-grant counters.
//
// state     | meaning
// CORE_PRI  | core wins contention; DMA served only when core idle
// DMA_FORCE | DMA starved STARVE_LIMIT cycles; DMA wins this cycle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [3:0]            core_be,
    input  logic [31:0]           core_addr,
    input  logic [31:0]           core_wdata,
    output logic                  core_stall,
    output logic [31:0]           core_rdata,
    output logic                  core_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [3:0]            dma_be,
    input  logic [31:0]           dma_addr,
    input  logic [31:0]           dma_wdata,
    output logic                  dma_gnt,
    output logic [31:0]           dma_rdata,
    output logic                  dma_rvalid,
    output logic                  mem_we,
    output logic                  mem_ren,
    output logic [3:0]            mem_byte_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           perf_conflicts,
    output logic [31:0]           perf_forced
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    owner_t        rd_owner;
    logic          rd_pending;
    logic          core_gnt;
    logic          any_gnt;
    logic          force_hit;
    logic [CW-1:0] starve_cnt;
    mem_req_t      core_bus;
    mem_req_t      dma_bus;
    mem_req_t      sel;
    logic [31:0]   core_rdata_q;
    logic [31:0]   dma_rdata_q;
    logic          unused_addr_bits;

    assign core_bus = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
    assign dma_bus  = '{we: dma_we,  be: dma_be,  addr: dma_addr,  wdata: dma_wdata};

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (state == DMA_FORCE) begin
            if (dma_req)       dma_gnt  = 1'b1;
            else if (core_req) core_gnt = 1'b1;
        end else begin
            if (core_req)      core_gnt = 1'b1;
            else if (dma_req)  dma_gnt  = 1'b1;
        end
    end

    assign any_gnt     = core_gnt || dma_gnt;
    assign sel         = core_gnt ? core_bus : dma_bus;
    assign core_stall  = core_req && !core_gnt;
    assign mem_we      = any_gnt && sel.we;
    assign mem_ren     = any_gnt && !sel.we;
    assign mem_byte_en = any_gnt ? sel.be : 4'b0000;
    assign mem_addr    = sel.addr[ADDR_WIDTH+1:2];
    assign mem_wdata   = sel.wdata;

    assign unused_addr_bits = ^{sel.addr[31:ADDR_WIDTH+2], sel.addr[1:0]};

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .dma_req    (dma_req),
        .dma_gnt    (dma_gnt),
        .starve_cnt (starve_cnt),
        .force_hit  (force_hit)
    );

    // DMA_FORCE always lasts one cycle: either DMA is granted or it withdrew its request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CORE_PRI;
        end else begin
            case (state)
                CORE_PRI:  if (force_hit) state <= DMA_FORCE;
                DMA_FORCE: state <= CORE_PRI;
                default:   state <= CORE_PRI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CORE;
        end else begin
            rd_pending <= mem_ren;
            if (mem_ren) rd_owner <= core_gnt ? OWN_CORE : OWN_DMA;
        end
    end

    assign core_rvalid = rd_pending && (rd_owner == OWN_CORE);
    assign dma_rvalid  = rd_pending && (rd_owner == OWN_DMA);

    // Return data is live from the memory in the valid cycle and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            if (core_rvalid) core_rdata_q <= mem_rdata;
            if (dma_rvalid)  dma_rdata_q  <= mem_rdata;
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_q;
    assign dma_rdata  = dma_rvalid  ? mem_rdata : dma_rdata_q;

`ifdef ARB_PERF_EN
    logic [31:0] conflicts_q;
    logic [31:0] forced_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflicts_q <= '0;
            forced_q    <= '0;
        end else begin
            if (core_req && dma_req && (conflicts_q != 32'hFFFF_FFFF))
                conflicts_q <= conflicts_q + 32'd1;
            if ((state == DMA_FORCE) && dma_gnt && core_req && (forced_q != 32'hFFFF_FFFF))
                forced_q <= forced_q + 32'd1;
        end
    end

    assign perf_conflicts = conflicts_q;
    assign perf_forced    = forced_q;
`else
    assign perf_conflicts = 32'd0;
    assign perf_forced    = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIMIT = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, dma_req, dma_we;
    logic [3:0]    core_be, dma_be;
    logic [31:0]   core_addr, core_wdata, dma_addr, dma_wdata;
    logic          core_stall, core_rvalid, dma_gnt, dma_rvalid;
    logic [31:0]   core_rdata, dma_rdata;
    logic          mem_we, mem_ren;
    logic [3:0]    mem_byte_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [31:0]   perf_conflicts, perf_forced;

    int checks = 0;
    int errors = 0;

    // reference model: consecutive denied DMA cycles, pending read owner, held return data
    int          denied;
    bit          pend_core, pend_dma;
    logic [31:0] exp_crd, exp_drd;
    int          m_conf, m_forced;
    logic        obs_dgnt, obs_ren, obs_stall;
    logic [31:0] obs_addr;

    dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_we(mem_we), .mem_ren(mem_ren), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_conflicts(perf_conflicts), .perf_forced(perf_forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied = 0; pend_core = 0; pend_dma = 0;
        exp_crd = '0; exp_drd = '0; m_conf = 0; m_forced = 0;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
        dma_req = 0; dma_we = 0; dma_be = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    // one clock cycle: check all outputs at the negedge against the model, then advance it
    task automatic tick();
        bit          forced, dg, cg;
        logic [31:0] a;
        mem_rdata = $urandom();
        @(negedge clk);
        forced = (denied >= LIMIT);
        dg = dma_req && (forced || !core_req);
        cg = core_req && !dg;
        chk("core_stall", core_stall, core_req && !cg);
        chk("dma_gnt", dma_gnt, dg);
        chk("mem_we", mem_we, (cg && core_we) || (dg && dma_we));
        chk("mem_ren", mem_ren, (cg && !core_we) || (dg && !dma_we));
        chk("mem_byte_en", mem_byte_en, cg ? core_be : (dg ? dma_be : 4'b0000));
        if (cg || dg) begin
            a = cg ? core_addr : dma_addr;
            chk("mem_addr", mem_addr, a[AW+1:2]);
            chk("mem_wdata", mem_wdata, cg ? core_wdata : dma_wdata);
        end
        if (pend_core) exp_crd = mem_rdata;
        if (pend_dma)  exp_drd = mem_rdata;
        chk("core_rvalid", core_rvalid, pend_core);
        chk("dma_rvalid", dma_rvalid, pend_dma);
        chk("core_rdata", core_rdata, exp_crd);
        chk("dma_rdata", dma_rdata, exp_drd);
`ifdef ARB_PERF_EN
        chk("perf_conflicts", perf_conflicts, m_conf);
        chk("perf_forced", perf_forced, m_forced);
`else
        chk("perf_conflicts", perf_conflicts, 0);
        chk("perf_forced", perf_forced, 0);
`endif
        obs_dgnt = dma_gnt; obs_ren = mem_ren; obs_stall = core_stall;
        obs_addr = 32'(mem_addr);
        if (core_req && dma_req) m_conf++;
        if (dg && forced && core_req) m_forced++;
        denied    = (dma_req && !dg) ? denied + 1 : 0;
        pend_core = cg && !core_we;
        pend_dma  = dg && !dma_we;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] gnt_pat;
        idle_inputs();
        mem_rdata = '0;
        model_reset();
        rst = 0;
        #2;
        chk("rst_core_rvalid", core_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_state", 32'(u_dut.state), 32'(CORE_PRI));
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // 1: core-only read of 0x10
        core_req = 1; core_addr = 32'h10;
        tick();
        chk("t1_mem_addr", obs_addr, 4);
        chk("t1_mem_ren", obs_ren, 1);
        chk("t1_stall", obs_stall, 0);
        idle_inputs();
        tick();

        // 2: sustained contention, DMA gets cycle 5
        core_req = 1; core_addr = 32'h40; dma_req = 1; dma_addr = 32'h80;
        gnt_pat = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            gnt_pat[i] = obs_dgnt;
        end
        chk("t2_gnt_pattern", 32'(gnt_pat), 32'b010000);
        idle_inputs();
        tick();

        // 3: DMA partial write, then core read of the same word
        dma_req = 1; dma_we = 1; dma_be = 4'b0011; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        core_req = 1; core_addr = 32'h20;
        tick();
        idle_inputs();
        tick();

        // 4: core read 0x8 as DMA starves out, forced DMA read 0xC next
        core_req = 1; core_addr = 32'h4; dma_req = 1; dma_addr = 32'hC;
        for (int i = 0; i < LIMIT - 1; i++) tick();
        core_addr = 32'h8;
        tick();
        tick();
        chk("t4_forced_gnt", obs_dgnt, 1);
        idle_inputs();
        tick();

        // 5: reset while a DMA read is returning
        dma_req = 1; dma_addr = 32'h30;
        tick();
        idle_inputs();
        rst = 0;
        #1;
        model_reset();
        chk("t5_dma_rvalid", dma_rvalid, 0);
        chk("t5_dma_rdata", dma_rdata, 0);
        chk("t5_state", 32'(u_dut.state), 32'(CORE_PRI));
        chk("t5_starve_cnt", 32'(u_dut.starve_cnt), 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // 6: DMA withdraws after three denials
        core_req = 1; core_addr = 32'h14; dma_req = 1; dma_addr = 32'h18;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_cnt3", 32'(u_dut.starve_cnt), 3);
        dma_req = 0;
        tick();
        chk("t6_no_gnt", obs_dgnt, 0);
        chk("t6_cnt0", 32'(u_dut.starve_cnt), 0);
        chk("t6_state", 32'(u_dut.state), 32'(CORE_PRI));
        idle_inputs();
        tick();

        // randomized traffic: core holds while stalled, DMA mostly holds until granted
        for (int n = 0; n < 400; n++) begin
            if (!(core_req && obs_stall)) begin
                core_req = ($urandom_range(0, 3) != 0); core_we = $urandom_range(0, 1);
                core_be = 4'($urandom()); core_addr = $urandom(); core_wdata = $urandom();
            end
            if (!(dma_req && !obs_dgnt) || ($urandom_range(0, 15) == 0)) begin
                dma_req = ($urandom_range(0, 1) != 0); dma_we = $urandom_range(0, 1);
                dma_be = 4'($urandom()); dma_addr = $urandom(); dma_wdata = $urandom();
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
